bus_timer_responder: RTL and testbench

//  Memory-mapped machine timer that responds on the core's byte-wide memory

---
 rtl/bus_timer_responder.sv | 150 +++++++++++++++
 tb/tb_bus_timer_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_responder.sv
// rtl/bus_timer_responder.sv - memory-mapped machine timer on the byte-wide core bus
module bus_timer_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_F000,
    parameter int          WAIT_CYCLES = 2,
    parameter int          PRESCALE    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        readMem,
    input  logic        writeMem,
    input  logic [31:0] addressBus,
    input  logic [7:0]  dataBusIn,
    output logic        memDataReady,
    output logic [7:0]  dataBusOut,
    output logic        machineTimerInterrupt,
    output logic        machineSoftwareInterrupt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [1:0]    state;
    logic [CW-1:0] waitCnt;
    logic [4:0]    reqOffset;
    logic          reqWrite;
    logic [7:0]    reqData;

    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic [63:0]   snapshot;
    logic [1:0]    ctrl;
    logic [PW-1:0] presc;

    logic [31:0]   offset;
    logic          hit;
    logic          reqValid;
    logic          tick;
    logic          commitWrite;
    logic [7:0]    readData;
    logic [63:0]   mtimeNext;

    // Offsets below BASE_ADDR wrap to large values, so a single compare decodes the window.
    assign offset      = addressBus - BASE_ADDR;
    assign hit         = offset < 32'd32;
    assign reqValid    = hit && (readMem ^ writeMem);
    assign tick        = ctrl[0] && (presc == PW'(PRESCALE - 1));
    assign commitWrite = (state == ST_ACK) && reqWrite;

    assign memDataReady = (state == ST_ACK);
    assign dataBusOut   = ((state == ST_ACK) && !reqWrite) ? readData : 8'h00;

    // Read mux: byte 0 of mtime is live, the rest come from the snapshot taken with it.
    always_comb begin
        readData = 8'h00;
        if (reqOffset[4:3] == 2'b00) begin
            if (reqOffset[2:0] == 3'd0) begin
                readData = mtime[7:0];
            end else begin
                readData = snapshot[{reqOffset[2:0], 3'b000} +: 8];
            end
        end else if (reqOffset[4:3] == 2'b01) begin
            readData = mtimecmp[{reqOffset[2:0], 3'b000} +: 8];
        end else if (reqOffset == 5'h10) begin
            readData = {6'b000000, ctrl};
        end
    end

    // Next mtime: increment first, then a committed byte write overrides its own byte.
    always_comb begin
        mtimeNext = tick ? (mtime + 64'd1) : mtime;
        if (commitWrite && (reqOffset[4:3] == 2'b00)) begin
            mtimeNext[{reqOffset[2:0], 3'b000} +: 8] = reqData;
        end
    end

    // Bus handshake: accept, count out the wait, ack once, then wait for the request to drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            waitCnt   <= '0;
            reqOffset <= 5'd0;
            reqWrite  <= 1'b0;
            reqData   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reqValid) begin
                        reqOffset <= offset[4:0];
                        reqWrite  <= writeMem;
                        reqData   <= dataBusIn;
                        waitCnt   <= CW'(WAIT_CYCLES);
                        state     <= (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!readMem && !writeMem) begin
                        state <= ST_IDLE;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                        if (waitCnt == CW'(1)) begin
                            state <= ST_ACK;
                        end
                    end
                end
                ST_ACK: state <= ST_HOLD;
                ST_HOLD: begin
                    if (!readMem && !writeMem) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Timer registers, read snapshot and registered interrupt levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime                    <= 64'd0;
            mtimecmp                 <= 64'hFFFF_FFFF_FFFF_FFFF;
            snapshot                 <= 64'd0;
            ctrl                     <= 2'b00;
            presc                    <= '0;
            machineTimerInterrupt    <= 1'b0;
            machineSoftwareInterrupt <= 1'b0;
        end else begin
            mtime <= mtimeNext;
            if (ctrl[0]) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            if (commitWrite && (reqOffset[4:3] == 2'b01)) begin
                mtimecmp[{reqOffset[2:0], 3'b000} +: 8] <= reqData;
            end
            if (commitWrite && (reqOffset == 5'h10)) begin
                ctrl <= reqData[1:0];
            end
            if ((state == ST_ACK) && !reqWrite && (reqOffset == 5'h00)) begin
                snapshot <= mtime;
            end
            machineTimerInterrupt    <= ctrl[0] && (mtime >= mtimecmp);
            machineSoftwareInterrupt <= ctrl[1];
        end
    end

endmodule

// File: tb/tb_bus_timer_responder.sv
// tb/tb_bus_timer_responder.sv - directed self-checking bench for bus_timer_responder
module tb_bus_timer_responder;

    localparam logic [31:0] BASE = 32'h0000_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic        readMem;
    logic        writeMem;
    logic [31:0] addressBus;
    logic [7:0]  dataBusIn;
    logic        memDataReady;
    logic [7:0]  dataBusOut;
    logic        machineTimerInterrupt;
    logic        machineSoftwareInterrupt;

    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;

    bus_timer_responder #(
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(2),
        .PRESCALE   (4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .readMem                 (readMem),
        .writeMem                (writeMem),
        .addressBus              (addressBus),
        .dataBusIn               (dataBusIn),
        .memDataReady            (memDataReady),
        .dataBusOut              (dataBusOut),
        .machineTimerInterrupt   (machineTimerInterrupt),
        .machineSoftwareInterrupt(machineSoftwareInterrupt)
    );

    // Free-running clock and rising-edge counter used for latency arithmetic.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Absolute time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus transfer, started and finished on a falling edge; returns read data and cycle stamps.
    task automatic busXfer(input logic wr, input logic [31:0] addr, input logic [7:0] wdata,
                           output logic [7:0] rdata, output int reqCyc, output int ackCyc);
        addressBus = addr;
        dataBusIn  = wdata;
        readMem    = !wr;
        writeMem   = wr;
        reqCyc     = cyc;
        ackCyc     = -1;
        rdata      = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (memDataReady) begin
                rdata  = dataBusOut;
                ackCyc = cyc;
                break;
            end
        end
        if (ackCyc < 0) checkVal("ack timeout", 64'd0, 64'd1);
        readMem  = 1'b0;
        writeMem = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wrReg(input logic [4:0] off, input logic [7:0] d);
        logic [7:0] r;
        int a;
        int b;
        busXfer(1'b1, BASE + {27'd0, off}, d, r, a, b);
    endtask

    task automatic rdCheck(input string tag, input logic [4:0] off, input logic [7:0] exp);
        logic [7:0] r;
        int a;
        int b;
        busXfer(1'b0, BASE + {27'd0, off}, 8'h00, r, a, b);
        checkVal(tag, {56'd0, r}, {56'd0, exp});
    endtask

    task automatic countAcks(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (memDataReady) cnt++;
        end
    endtask

    task automatic doReset();
        rst      = 1'b1;
        readMem  = 1'b0;
        writeMem = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        logic [7:0]  rd;
        logic [63:0] expT;
        int rq;
        int ak;
        int ce;
        int cnt;

        addressBus = 32'd0;
        dataBusIn  = 8'h00;
        doReset();

        // Reset state and first read latency
        checkVal("reset ready", {63'd0, memDataReady}, 64'd0);
        checkVal("reset dout", {56'd0, dataBusOut}, 64'd0);
        checkVal("reset mti", {63'd0, machineTimerInterrupt}, 64'd0);
        checkVal("reset msi", {63'd0, machineSoftwareInterrupt}, 64'd0);
        busXfer(1'b0, BASE + 32'h10, 8'h00, rd, rq, ak);
        checkVal("t1 latency", 64'(ak - rq), 64'd3);
        checkVal("t1 ctrl", {56'd0, rd}, 64'h00);
        rdCheck("t1 cmp0", 5'h08, 8'hFF);
        rdCheck("t1 cmp7", 5'h0F, 8'hFF);

        // Run 40 enabled clocks, then read mtime bytes
        busXfer(1'b1, BASE + 32'h10, 8'h01, rd, rq, ce);
        while (cyc < ce + 38) @(negedge clk);
        busXfer(1'b0, BASE, 8'h00, rd, rq, ak);
        checkVal("t2 ack cycle", 64'(ak), 64'(ce + 41));
        checkVal("t2 mtime byte0", {56'd0, rd}, 64'd10);
        for (int i = 1; i < 8; i++) rdCheck($sformatf("t2 byte%0d", i), 5'(i), 8'h00);

        // Timer interrupt on compare and clear by raising mtimecmp
        doReset();
        wrReg(5'h08, 8'h14);
        for (int i = 9; i < 16; i++) wrReg(5'(i), 8'h00);
        busXfer(1'b1, BASE + 32'h10, 8'h01, rd, rq, ce);
        checkVal("t3 mti early", {63'd0, machineTimerInterrupt}, 64'd0);
        while (cyc < ce + 81) @(negedge clk);
        checkVal("t3 mti before", {63'd0, machineTimerInterrupt}, 64'd0);
        @(negedge clk);
        checkVal("t3 mti rise", {63'd0, machineTimerInterrupt}, 64'd1);
        wrReg(5'h08, 8'hFF);
        checkVal("t3 mti fall", {63'd0, machineTimerInterrupt}, 64'd0);

        // mtime wraps from all ones to zero
        doReset();
        for (int i = 0; i < 8; i++) wrReg(5'(i), 8'hFF);
        busXfer(1'b1, BASE + 32'h10, 8'h01, rd, rq, ce);
        busXfer(1'b0, BASE, 8'h00, rd, rq, ak);
        expT = 64'hFFFF_FFFF_FFFF_FFFF + 64'((ak - ce - 1) / 4);
        checkVal("t4 wrap byte0", {56'd0, rd}, {56'd0, expT[7:0]});
        for (int i = 1; i < 8; i++) rdCheck($sformatf("t4 byte%0d", i), 5'(i), expT[8*i +: 8]);
        busXfer(1'b0, BASE, 8'h00, rd, rq, ak);
        expT = 64'hFFFF_FFFF_FFFF_FFFF + 64'((ak - ce - 1) / 4);
        checkVal("t4 later byte0", {56'd0, rd}, {56'd0, expT[7:0]});

        // Misses, double requests, held request
        doReset();
        addressBus = BASE + 32'h20;
        readMem    = 1'b1;
        countAcks(10, cnt);
        checkVal("t5 miss above", 64'(cnt), 64'd0);
        addressBus = BASE - 32'd1;
        countAcks(10, cnt);
        checkVal("t5 miss below", 64'(cnt), 64'd0);
        addressBus = BASE + 32'h10;
        writeMem   = 1'b1;
        countAcks(10, cnt);
        checkVal("t5 rd+wr", 64'(cnt), 64'd0);
        writeMem = 1'b0;
        countAcks(12, cnt);
        checkVal("t5 held pulses", 64'(cnt), 64'd1);
        readMem = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reserved bytes and CTRL masking
        wrReg(5'h11, 8'hFF);
        rdCheck("t5 reserved", 5'h11, 8'h00);
        wrReg(5'h10, 8'hFE);
        rdCheck("t5 ctrl mask", 5'h10, 8'h02);
        checkVal("t5 msi", {63'd0, machineSoftwareInterrupt}, 64'd1);

        // Write dropped during WAIT is aborted
        doReset();
        addressBus = BASE + 32'h10;
        dataBusIn  = 8'h02;
        writeMem   = 1'b1;
        @(negedge clk);
        writeMem = 1'b0;
        countAcks(6, cnt);
        checkVal("abort acks", 64'(cnt), 64'd0);
        checkVal("abort msi", {63'd0, machineSoftwareInterrupt}, 64'd0);
        rdCheck("abort ctrl", 5'h10, 8'h00);

        // Reset during WAIT of a write
        wrReg(5'h00, 8'h55);
        wrReg(5'h08, 8'h12);
        addressBus = BASE + 32'h10;
        dataBusIn  = 8'h02;
        writeMem   = 1'b1;
        @(negedge clk);
        rst      = 1'b1;
        writeMem = 1'b0;
        @(negedge clk);
        checkVal("t6 ready in rst", {63'd0, memDataReady}, 64'd0);
        rst = 1'b0;
        countAcks(6, cnt);
        checkVal("t6 acks", 64'(cnt), 64'd0);
        checkVal("t6 msi", {63'd0, machineSoftwareInterrupt}, 64'd0);
        checkVal("t6 mti", {63'd0, machineTimerInterrupt}, 64'd0);
        rdCheck("t6 ctrl", 5'h10, 8'h00);
        rdCheck("t6 cmp0", 5'h08, 8'hFF);
        rdCheck("t6 mtime0", 5'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
